// File: rtl/rep_sequencer.sv
// rep_sequencer
//   Sequences REP / REPE / REPNE prefixed string instructions after prefix
//   decode. One decoded instruction is accepted in IDLE. The string op is
//   issued to the execution unit once per iteration. (E)CX is decremented
//   and written back after every REP iteration. The ZF termination rule
//   applies to CMPS/SCAS. Non-REP instructions run as a single iteration
//   with no ECX write.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   instr_valid/ready  instruction accept handshake (ready only in IDLE)
//   prefix_rep         0 none, 1 REPNE, 2 REP/REPE, 3 reserved (= none)
//   prefix_addr16      count is CX rather than ECX
//   is_string_op       MOVS/STOS/LODS/CMPS/SCAS
//   zf_sensitive       CMPS/SCAS: ZF may terminate REPE/REPNE
//   ecx_in             ECX at accept
//   iter_valid/ready   one-iteration request to the execution unit
//   iter_done, iter_zf iteration completion and its ZF result
//   ecx_we, ecx_out    one-cycle ECX write-back pulse and value
//   retire_valid/ready instruction completion handshake
//   retire_overflow    qualifies retire: iteration bound hit before termination

module rep_sequencer #(
    parameter int unsigned MAX_ITERS = 256,
    parameter int unsigned ITER_W    = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [1:0]  prefix_rep,
    input  logic        prefix_addr16,
    input  logic        is_string_op,
    input  logic        zf_sensitive,
    input  logic [31:0] ecx_in,
    output logic        iter_valid,
    input  logic        iter_ready,
    input  logic        iter_done,
    input  logic        iter_zf,
    output logic        ecx_we,
    output logic [31:0] ecx_out,
    output logic        retire_valid,
    input  logic        retire_ready,
    output logic        retire_overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    // rep_kind: 0 single-shot, 1 REPNE, 2 REPE (reserved prefix folded to 0)
    logic [1:0]         rep_kind_q, rep_kind_d;
    logic               addr16_q, addr16_d;
    logic               zf_sens_q, zf_sens_d;
    logic [15:0]        hi16_q, hi16_d;
    logic [31:0]        count_q, count_d;
    logic [ITER_W-1:0]  iters_q, iters_d;
    logic [31:0]        ecx_out_q, ecx_out_d;
    logic               ecx_we_q, ecx_we_d;
    logic               ovf_q, ovf_d;

    logic               rep_accept;
    logic [31:0]        count_m1;
    logic [ITER_W-1:0]  iters_inc;
    logic               zf_term;
    logic               terminate;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rep_kind_q <= 2'd0;
            addr16_q   <= 1'b0;
            zf_sens_q  <= 1'b0;
            hi16_q     <= '0;
            count_q    <= '0;
            iters_q    <= '0;
            ecx_out_q  <= '0;
            ecx_we_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rep_kind_q <= rep_kind_d;
            addr16_q   <= addr16_d;
            zf_sens_q  <= zf_sens_d;
            hi16_q     <= hi16_d;
            count_q    <= count_d;
            iters_q    <= iters_d;
            ecx_out_q  <= ecx_out_d;
            ecx_we_q   <= ecx_we_d;
            ovf_q      <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rep_kind_d = rep_kind_q;
        addr16_d   = addr16_q;
        zf_sens_d  = zf_sens_q;
        hi16_d     = hi16_q;
        count_d    = count_q;
        iters_d    = iters_q;
        ecx_out_d  = ecx_out_q;
        ecx_we_d   = 1'b0;
        ovf_d      = ovf_q;

        rep_accept = is_string_op && (prefix_rep == 2'd1 || prefix_rep == 2'd2);
        // CHECK guarantees count_q != 0 before any decrement, so no underflow;
        // in 16-bit mode the count's upper half is zero and stays zero.
        count_m1   = count_q - 32'd1;
        iters_inc  = iters_q + ITER_W'(1);
        zf_term    = zf_sens_q &&
                     ((rep_kind_q == 2'd2 && !iter_zf) ||
                      (rep_kind_q == 2'd1 &&  iter_zf));
        terminate  = (count_m1 == 32'd0) || zf_term;

        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    rep_kind_d = rep_accept ? prefix_rep : 2'd0;
                    addr16_d   = prefix_addr16;
                    zf_sens_d  = zf_sensitive;
                    hi16_d     = ecx_in[31:16];
                    count_d    = prefix_addr16 ? {16'h0000, ecx_in[15:0]} : ecx_in;
                    iters_d    = '0;
                    ovf_d      = 1'b0;
                    state_d    = rep_accept ? S_CHECK : S_ISSUE;
                end
            end

            S_CHECK: begin
                state_d = (count_q == 32'd0) ? S_DONE : S_ISSUE;
            end

            S_ISSUE: begin
                if (iter_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (iter_done) begin
                    if (rep_kind_q == 2'd0) begin
                        state_d = S_DONE;
                    end else begin
                        count_d   = count_m1;
                        iters_d   = iters_inc;
                        ecx_we_d  = 1'b1;
                        ecx_out_d = addr16_q ? {hi16_q, count_m1[15:0]} : count_m1;
                        // Normal termination wins over the iteration bound.
                        if (terminate) begin
                            state_d = S_DONE;
                        end else if (iters_inc == ITER_W'(MAX_ITERS)) begin
                            state_d = S_DONE;
                            ovf_d   = 1'b1;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end
                end
            end

            S_DONE: begin
                if (retire_ready) begin
                    state_d = S_IDLE;
                    ovf_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready     = (state_q == S_IDLE);
        iter_valid      = (state_q == S_ISSUE);
        retire_valid    = (state_q == S_DONE);
        retire_overflow = (state_q == S_DONE) && ovf_q;
        ecx_we          = ecx_we_q;
        ecx_out         = ecx_out_q;
    end

endmodule

// File: tb/tb_rep_sequencer.sv
// Testbench for rep_sequencer: directed table, hand-written reset/stall
// sequence, and randomized instructions checked against a reference model.

module tb_rep_sequencer;

    localparam int unsigned MAXI = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  prefix_rep;
    logic        prefix_addr16;
    logic        is_string_op;
    logic        zf_sensitive;
    logic [31:0] ecx_in;
    logic        iter_valid;
    logic        iter_ready;
    logic        iter_done;
    logic        iter_zf;
    logic        ecx_we;
    logic [31:0] ecx_out;
    logic        retire_valid;
    logic        retire_ready;
    logic        retire_overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    rep_sequencer #(
        .MAX_ITERS(MAXI),
        .ITER_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .prefix_rep(prefix_rep),
        .prefix_addr16(prefix_addr16),
        .is_string_op(is_string_op),
        .zf_sensitive(zf_sensitive),
        .ecx_in(ecx_in),
        .iter_valid(iter_valid),
        .iter_ready(iter_ready),
        .iter_done(iter_done),
        .iter_zf(iter_zf),
        .ecx_we(ecx_we),
        .ecx_out(ecx_out),
        .retire_valid(retire_valid),
        .retire_ready(retire_ready),
        .retire_overflow(retire_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [1:0]  p;
        logic        a16;
        logic        str;
        logic        zs;
        logic [31:0] ecx;
        logic [31:0] zf;
        int          exp_n;
        int          exp_nwe;
        logic [31:0] exp_last;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: iterate the REP rules directly on an integer count.
    task automatic model(input logic [1:0] p, input logic a16, input logic str,
                         input logic zs, input logic [31:0] ecx, input logic [31:0] zf,
                         output int n, output logic ovf);
        logic [31:0] cnt;
        exp_q.delete();
        n = 0;
        ovf = 1'b0;
        if (!((p == 2'd1 || p == 2'd2) && str)) begin
            n = 1;
            return;
        end
        cnt = a16 ? {16'h0000, ecx[15:0]} : ecx;
        while (cnt != 0) begin
            n++;
            cnt = cnt - 1;
            exp_q.push_back(a16 ? {ecx[31:16], cnt[15:0]} : cnt);
            if (cnt == 0) break;
            if (zs && ((p == 2'd2 && !zf[n-1]) || (p == 2'd1 && zf[n-1]))) break;
            if (n == int'(MAXI)) begin
                ovf = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_instr(input string nm, input logic [1:0] p, input logic a16,
                             input logic str, input logic zs, input logic [31:0] ecx,
                             input logic [31:0] zf, input bit rnd,
                             output int n_iss, output int n_we,
                             output logic [31:0] last, output logic ovf_obs);
        int   exp_n;
        logic exp_ovf;
        int   k;
        int   cyc;
        int   first_iv;
        bit   waiting;
        bit   retired;
        bit   repb;

        model(p, a16, str, zs, ecx, zf, exp_n, exp_ovf);
        repb = (p == 2'd1 || p == 2'd2) && str;
        obs_q.delete();
        n_iss = 0; k = 0; cyc = 1; first_iv = 0;
        waiting = 0; retired = 0; ovf_obs = 1'b0; last = '0;

        @(negedge clk);
        check({nm, ":instr_ready"}, {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        prefix_rep = p; prefix_addr16 = a16; is_string_op = str;
        zf_sensitive = zs; ecx_in = ecx;
        @(negedge clk);
        // Garbage on the instruction fields: everything must have been latched.
        instr_valid = 1'b0;
        prefix_rep = 2'($urandom); prefix_addr16 = 1'($urandom);
        is_string_op = 1'($urandom); zf_sensitive = 1'($urandom);
        ecx_in = $urandom;

        while (!retired && cyc < 2000) begin
            iter_ready = 1'b0;
            retire_ready = 1'b0;
            iter_done = rnd ? 1'($urandom) : 1'b0;
            iter_zf = 1'($urandom);
            if (ecx_we) begin
                obs_q.push_back(ecx_out);
                check({nm, ":we_with_issue_or_done"}, {31'd0, iter_valid | retire_valid}, 32'd1);
            end
            if (waiting) begin
                if (rnd && ($urandom % 3) == 0) begin
                    iter_done = 1'b0;
                end else begin
                    iter_done = 1'b1;
                    iter_zf = zf[k];
                    k++;
                    waiting = 0;
                end
            end
            if (iter_valid) begin
                if (first_iv == 0) first_iv = cyc;
                if (!(rnd && ($urandom % 3) == 0)) begin
                    iter_ready = 1'b1;
                    n_iss++;
                    waiting = 1;
                end
            end
            if (retire_valid) begin
                ovf_obs = retire_overflow;
                if (!(rnd && ($urandom % 3) == 0)) begin
                    retire_ready = 1'b1;
                    retired = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        iter_ready = 1'b0;
        retire_ready = 1'b0;
        iter_done = 1'b0;

        check({nm, ":retired"}, {31'd0, retired}, 32'd1);
        check({nm, ":iterations"}, n_iss, exp_n);
        check({nm, ":ecx_we_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s:ecx_out[%0d]", nm, i), obs_q[i], exp_q[i]);
        check({nm, ":overflow"}, {31'd0, ovf_obs}, {31'd0, exp_ovf});
        if (exp_n > 0)
            check({nm, ":first_issue_latency"}, first_iv, repb ? 2 : 1);
        n_we = obs_q.size();
        if (n_we > 0) last = obs_q[n_we-1];
    endtask

    vec_t tbl[$];

    initial begin
        int          n_iss;
        int          n_we;
        logic [31:0] last;
        logic        ovf;

        tbl = '{
            '{"nonrep_movs",   2'd0, 1'b0, 1'b1, 1'b0, 32'd5,         32'h0, 1, 0, 32'h0,         1'b0},
            '{"f3_stos_3",     2'd2, 1'b0, 1'b1, 1'b0, 32'd3,         32'h0, 3, 3, 32'h0,         1'b0},
            '{"f3_cmps_zf",    2'd2, 1'b0, 1'b1, 1'b1, 32'd10,        32'h3, 3, 3, 32'd7,         1'b0},
            '{"f2_cmps_zf",    2'd1, 1'b0, 1'b1, 1'b1, 32'd10,        32'h2, 2, 2, 32'd8,         1'b0},
            '{"f3_cx_zero",    2'd2, 1'b1, 1'b1, 1'b0, 32'hABCD0000,  32'h0, 0, 0, 32'h0,         1'b0},
            '{"f3_cx_two",     2'd2, 1'b1, 1'b1, 1'b0, 32'hABCD0002,  32'h0, 2, 2, 32'hABCD0000,  1'b0},
            '{"f3_overflow",   2'd2, 1'b0, 1'b1, 1'b0, 32'd1000,      32'h0, 4, 4, 32'd996,       1'b1},
            '{"f3_exact_max",  2'd2, 1'b0, 1'b1, 1'b0, 32'd4,         32'h0, 4, 4, 32'h0,         1'b0},
            '{"reserved_pfx",  2'd3, 1'b0, 1'b1, 1'b0, 32'd7,         32'h0, 1, 0, 32'h0,         1'b0},
            '{"f2_nonstring",  2'd1, 1'b0, 1'b0, 1'b0, 32'd9,         32'h0, 1, 0, 32'h0,         1'b0},
            '{"f3_cx_ffff",    2'd2, 1'b1, 1'b1, 1'b0, 32'h0001FFFF,  32'h0, 4, 4, 32'h0001FFFB,  1'b1},
            '{"f3_ecx_64k",    2'd2, 1'b0, 1'b1, 1'b0, 32'h00010000,  32'h0, 4, 4, 32'h0000FFFC,  1'b1},
            '{"f3_movs_nozf",  2'd2, 1'b0, 1'b1, 1'b0, 32'd2,         32'h0, 2, 2, 32'h0,         1'b0}
        };

        rst_n = 1'b0;
        instr_valid = 1'b0; prefix_rep = 2'd0; prefix_addr16 = 1'b0;
        is_string_op = 1'b0; zf_sensitive = 1'b0; ecx_in = '0;
        iter_ready = 1'b0; iter_done = 1'b0; iter_zf = 1'b0; retire_ready = 1'b0;

        #12;
        check("rst:instr_ready", {31'd0, instr_ready}, 32'd1);
        check("rst:iter_valid", {31'd0, iter_valid}, 32'd0);
        check("rst:retire_valid", {31'd0, retire_valid}, 32'd0);
        check("rst:ecx_we", {31'd0, ecx_we}, 32'd0);
        check("rst:ecx_out", ecx_out, 32'd0);
        check("rst:overflow", {31'd0, retire_overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_instr(tbl[i].nm, tbl[i].p, tbl[i].a16, tbl[i].str, tbl[i].zs,
                      tbl[i].ecx, tbl[i].zf, 1'b0, n_iss, n_we, last, ovf);
            check({tbl[i].nm, ":tbl_iters"}, n_iss, tbl[i].exp_n);
            check({tbl[i].nm, ":tbl_nwe"}, n_we, tbl[i].exp_nwe);
            if (tbl[i].exp_nwe > 0)
                check({tbl[i].nm, ":tbl_last_ecx"}, last, tbl[i].exp_last);
            check({tbl[i].nm, ":tbl_ovf"}, {31'd0, ovf}, {31'd0, tbl[i].exp_ovf});
        end

        // Stall in ISSUE, then reset while WAIT is in flight.
        @(negedge clk);
        instr_valid = 1'b1; prefix_rep = 2'd2; prefix_addr16 = 1'b0;
        is_string_op = 1'b1; zf_sensitive = 1'b0; ecx_in = 32'd5;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall:iter_valid[%0d]", i), {31'd0, iter_valid}, 32'd1);
            @(negedge clk);
        end
        iter_ready = 1'b1;
        @(negedge clk);
        iter_ready = 1'b0;
        check("stall:in_wait", {31'd0, iter_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst:instr_ready", {31'd0, instr_ready}, 32'd1);
        check("midrst:iter_valid", {31'd0, iter_valid}, 32'd0);
        check("midrst:retire_valid", {31'd0, retire_valid}, 32'd0);
        check("midrst:ecx_we", {31'd0, ecx_we}, 32'd0);
        check("midrst:ecx_out", ecx_out, 32'd0);
        @(negedge clk);
        iter_done = 1'b1;
        @(negedge clk);
        iter_done = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("postrst:quiet[%0d]", i),
                  {29'd0, instr_ready, ecx_we, retire_valid}, 32'd4);
        end

        // Randomized instructions against the reference model.
        for (int t = 0; t < 60; t++) begin
            logic [1:0]  p;
            logic        a16;
            logic [31:0] ecx;
            p   = 2'($urandom);
            a16 = 1'($urandom);
            ecx = ($urandom % 4 == 0) ? $urandom : {$urandom, 16'h0000} | 32'($urandom_range(0, 6));
            run_instr($sformatf("rand%0d", t), p, a16, 1'($urandom % 4 != 0),
                      1'($urandom), ecx, $urandom, 1'b1, n_iss, n_we, last, ovf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
